pc_sequencer: RTL and testbench

Fetch-side controller that owns the program counter and sequences instruction fetch. Runs a request/acknowledge handshake to instruction memory and hands each fetched word to decode with a valid/ready handshake. Applies branch/jump redirects and exception vectoring, including redirects that arrive while a fetch is still outstanding. Sits between execute (redirect source), instruction memory and decode.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/pc_next_sel.sv | 31 +++
 rtl/pc_sequencer.sv | 144 ++++++++++++++
 tb/tb_pc_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side program counter sequencer.
// Holds the FSM state encoding, default vectors and the sequential PC step.
// Imported by pc_next_sel and pc_sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
  localparam logic [31:0] PC_INCR          = 32'd4;

  // A fetch address is legal only when it is word aligned.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Redirect resolution: picks exception over branch redirect and checks alignment.
// Purely combinational, zero latency.
// No handshake; the caller decides when a take is allowed to act.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        exc_valid_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  output logic        take_o,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  // Exception wins; a misaligned redirect falls back to the exception vector.
  always_comb begin
    take_o       = exc_valid_i | redirect_valid_i;
    target_o     = EXC_VECTOR;
    misaligned_o = 1'b0;
    if (!exc_valid_i && redirect_valid_i) begin
      if (is_word_aligned(redirect_target_i)) begin
        target_o = redirect_target_i;
      end else begin
        misaligned_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the PC, fetches one word at a time over req/ack and buffers it for decode.
// One instruction per >=2 cycles; redirect lands on imem_addr the next cycle unless a fetch is outstanding.
// Decode stalls hold the buffered word; redirects during a fetch are parked until its ack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  input  logic        if_ready_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic        exc_valid_i,
  input  logic        halt_i,
  output logic        addr_err_o
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        addr_err_q, addr_err_d;

  logic        sel_take;
  logic [31:0] sel_target;
  logic        sel_misaligned;

  pc_next_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_sel (
    .exc_valid_i      (exc_valid_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_target_i(redirect_target_i),
    .take_o           (sel_take),
    .target_o         (sel_target),
    .misaligned_o     (sel_misaligned)
  );

  // Next-state logic: fetch sequencing, redirect handling and the decode buffer.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    // Redirects are ignored in HALT, so no error is flagged there either.
    addr_err_d    = sel_misaligned && (state_q != ST_HALT);

    unique case (state_q)
      ST_BOOT: begin
        if (sel_take) pc_d = sel_target;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (imem_ack_i) begin
          pend_d = 1'b0;
          if (sel_take) begin
            // Data belongs to the old path; refetch from the new target.
            pc_d = sel_target;
          end else if (pend_q) begin
            pc_d = pend_target_q;
          end else begin
            if_instr_d = imem_rdata_i;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + PC_INCR;
            state_d    = ST_HOLD;
          end
        end else if (sel_take) begin
          // Address must stay stable until ack, so park the target (last wins).
          pend_d        = 1'b1;
          pend_target_d = sel_target;
        end
      end

      ST_HOLD: begin
        if (sel_take) begin
          // Squash takes precedence over both acceptance and halt.
          if_valid_d = 1'b0;
          pc_d       = sel_target;
          state_d    = ST_FETCH;
        end else if (if_ready_i) begin
          if_valid_d = 1'b0;
          state_d    = halt_i ? ST_HALT : ST_FETCH;
        end
      end

      ST_HALT: begin
        if (exc_valid_i) begin
          pc_d    = EXC_VECTOR;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_BOOT;
    endcase
  end

  // State registers; reset abandons any outstanding fetch.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      pend_q        <= 1'b0;
      pend_target_q <= 32'h0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'h0;
      if_pc_q       <= 32'h0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign imem_req_o  = (state_q == ST_FETCH);
  assign imem_addr_o = pc_q;
  assign if_valid_o  = if_valid_q;
  assign if_instr_o  = if_instr_q;
  assign if_pc_o     = if_pc_q;
  assign addr_err_o  = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// The random run checks against a transaction-level model of fetch/redirect rules.
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EXC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic        halt;
  logic        addr_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_VECTOR(RV),
    .EXC_VECTOR  (EXC)
  ) dut (
    .clk_i            (clk),
    .reset_ni         (reset_n),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_ack_i       (imem_ack),
    .imem_rdata_i     (imem_rdata),
    .if_valid_o       (if_valid),
    .if_instr_o       (if_instr),
    .if_pc_o          (if_pc),
    .if_ready_i       (if_ready),
    .redirect_valid_i (redirect_valid),
    .redirect_target_i(redirect_target),
    .exc_valid_i      (exc_valid),
    .halt_i           (halt),
    .addr_err_o       (addr_err)
  );

  task automatic idle_inputs;
    imem_ack        = 1'b0;
    imem_rdata      = 32'h0;
    if_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    exc_valid       = 1'b0;
    halt            = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== RV) $display("FAIL reset_addr got=%h exp=%h", imem_addr, RV); else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", if_valid); else n_pass++;
    n_checks++; if (if_instr !== 32'h0) $display("FAIL reset_instr got=%h exp=0", if_instr); else n_pass++;
    n_checks++; if (if_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", if_pc); else n_pass++;
    n_checks++; if (addr_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", addr_err); else n_pass++;
    reset_n = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL boot_req got=%b exp=0", imem_req); else n_pass++;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== RV) $display("FAIL first_fetch got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RV); else n_pass++;
  endtask

  // Zero-wait ack with decode always ready: addresses 0x0, 0x4, 0x8.
  task automatic test_sequential;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) $display("FAIL seq_addr%0d got req=%b addr=%h exp addr=%h", i, imem_req, imem_addr, 32'(4 * i)); else n_pass++;
      d = $urandom;
      imem_ack = 1'b1; imem_rdata = d; if_ready = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== d) $display("FAIL seq_out%0d got v=%b pc=%h instr=%h exp pc=%h instr=%h", i, if_valid, if_pc, if_instr, 32'(4 * i), d); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_stall;
    logic [31:0] d;
    d = $urandom;
    imem_ack = 1'b1; imem_rdata = d; if_ready = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (5) begin
      n_checks++; if (if_valid !== 1'b1 || if_instr !== d || if_pc !== 32'hC || imem_req !== 1'b0) $display("FAIL stall_hold got v=%b instr=%h pc=%h req=%b exp v=1 instr=%h pc=c req=0", if_valid, if_instr, if_pc, imem_req, d); else n_pass++;
      @(negedge clk);
    end
    if_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_valid !== 1'b0) $display("FAIL stall_next got req=%b addr=%h v=%b exp req=1 addr=10 v=0", imem_req, imem_addr, if_valid); else n_pass++;
  endtask

  task automatic test_redirect_pending;
    logic [31:0] d;
    redirect_valid = 1'b1; redirect_target = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (3) begin
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) $display("FAIL pend_stable got req=%b addr=%h exp req=1 addr=10", imem_req, imem_addr); else n_pass++;
      @(negedge clk);
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; if_ready = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL pend_redirect got v=%b req=%b addr=%h exp v=0 req=1 addr=100", if_valid, imem_req, imem_addr); else n_pass++;
    d = $urandom;
    imem_ack = 1'b1; imem_rdata = d;
    @(negedge clk);
    imem_ack = 1'b0;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== d) $display("FAIL pend_target_fetch got v=%b pc=%h instr=%h exp pc=100 instr=%h", if_valid, if_pc, if_instr, d); else n_pass++;
  endtask

  task automatic test_misaligned;
    redirect_valid = 1'b1; redirect_target = 32'h202; if_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0; if_ready = 1'b0;
    n_checks++; if (addr_err !== 1'b1) $display("FAIL misalign_err got=%b exp=1", addr_err); else n_pass++;
    n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== EXC) $display("FAIL misalign_vec got v=%b req=%b addr=%h exp v=0 req=1 addr=%h", if_valid, imem_req, imem_addr, EXC); else n_pass++;
    @(negedge clk);
    n_checks++; if (addr_err !== 1'b0) $display("FAIL misalign_pulse got=%b exp=0", addr_err); else n_pass++;
  endtask

  task automatic test_exc_priority;
    imem_ack = 1'b1; imem_rdata = $urandom;
    @(negedge clk);
    imem_ack = 1'b0;
    exc_valid = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    @(negedge clk);
    exc_valid = 1'b0; redirect_valid = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== EXC || if_valid !== 1'b0) $display("FAIL exc_prio got req=%b addr=%h v=%b exp req=1 addr=%h v=0", imem_req, imem_addr, if_valid, EXC); else n_pass++;
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    imem_ack = 1'b1; imem_rdata = $urandom;
    @(negedge clk);
    imem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_target got=%h exp=fffffffc", imem_addr); else n_pass++;
    d = $urandom;
    imem_ack = 1'b1; imem_rdata = d;
    @(negedge clk);
    imem_ack = 1'b0;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== d) $display("FAIL wrap_out got v=%b pc=%h instr=%h exp pc=fffffffc instr=%h", if_valid, if_pc, if_instr, d); else n_pass++;
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL wrap_next got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); else n_pass++;
  endtask

  task automatic test_halt;
    imem_ack = 1'b1; imem_rdata = $urandom;
    @(negedge clk);
    imem_ack = 1'b0;
    halt = 1'b1; if_ready = 1'b1;
    @(negedge clk);
    halt = 1'b0; if_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || addr_err !== 1'b0) $display("FAIL halt_idle%0d got req=%b v=%b err=%b exp 0 0 0", i, imem_req, if_valid, addr_err); else n_pass++;
      redirect_valid = (i == 3); redirect_target = 32'h202;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    exc_valid = 1'b1;
    @(negedge clk);
    exc_valid = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== EXC) $display("FAIL halt_exit got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, EXC); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch;
    reset_n = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== RV || if_valid !== 1'b0) $display("FAIL midreset_fetch got req=%b addr=%h v=%b exp 0 %h 0", imem_req, imem_addr, if_valid, RV); else n_pass++;
    n_checks++; if (if_instr !== 32'h0 || if_pc !== 32'h0 || addr_err !== 1'b0) $display("FAIL midreset_out got instr=%h pc=%h err=%b exp 0 0 0", if_instr, if_pc, addr_err); else n_pass++;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RV) $display("FAIL late_ack got v=%b req=%b addr=%h exp v=0 req=1 addr=%h", if_valid, imem_req, imem_addr, RV); else n_pass++;
  endtask

  // Random latency, stalls, redirects and exceptions against a transaction model:
  // every request address, every delivered word and every error pulse is predicted.
  task automatic test_random;
    logic        exp_valid, exp_req, exp_err, in_flight, discard;
    logic        ack, rdy, rd, ex;
    logic [31:0] exp_addr, exp_vpc, exp_vinstr, cur_addr, tgt, eff, rdat, raw;
    int          lat, delivered, errs_seen;
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_valid = 1'b0; exp_req = 1'b0; exp_err = 1'b0; in_flight = 1'b0; discard = 1'b0;
    exp_addr = RV; exp_vpc = 32'h0; exp_vinstr = 32'h0; cur_addr = 32'h0;
    lat = 0; delivered = 0; errs_seen = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_checks++; if (if_valid !== exp_valid) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, if_valid, exp_valid); else n_pass++;
      n_checks++; if (imem_req !== exp_req) $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req); else n_pass++;
      n_checks++; if (addr_err !== exp_err) $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, addr_err, exp_err); else n_pass++;
      if (exp_valid) begin
        n_checks++; if (if_pc !== exp_vpc || if_instr !== exp_vinstr) $display("FAIL rnd_data cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h", cyc, if_pc, if_instr, exp_vpc, exp_vinstr); else n_pass++;
      end
      if (exp_err) errs_seen++;
      if (imem_req && !in_flight) begin
        n_checks++; if (imem_addr !== exp_addr) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, exp_addr); else n_pass++;
        in_flight = 1'b1; cur_addr = exp_addr; discard = 1'b0; lat = $urandom_range(0, 3);
      end else if (in_flight) begin
        n_checks++; if (imem_addr !== cur_addr) $display("FAIL rnd_stable cyc=%0d got=%h exp=%h", cyc, imem_addr, cur_addr); else n_pass++;
      end
      ack = in_flight && (lat == 0);
      if (in_flight && lat > 0) lat--;
      rdat = $urandom;
      rdy  = ($urandom_range(0, 2) != 0);
      rd   = ($urandom_range(0, 9) == 0);
      ex   = ($urandom_range(0, 29) == 0);
      raw  = $urandom;
      case ($urandom_range(0, 7))
        0:       tgt = raw;
        1:       tgt = 32'hFFFF_FFFC;
        default: tgt = raw & 32'hFFFF_FFFC;
      endcase
      imem_ack = ack; imem_rdata = rdat; if_ready = rdy;
      redirect_valid = rd; redirect_target = tgt; exc_valid = ex;
      // Model: exception beats redirect; misaligned redirect vectors and flags an error.
      exp_err = rd && !ex && (tgt[1:0] != 2'b00);
      eff = (ex || tgt[1:0] != 2'b00) ? EXC : tgt;
      if (exp_valid) begin
        if (rd || ex) begin
          exp_valid = 1'b0; exp_addr = eff;
        end else if (rdy) begin
          exp_valid = 1'b0; delivered++;
        end
      end
      if (in_flight) begin
        if (rd || ex) begin
          discard = 1'b1; exp_addr = eff;
        end
        if (ack) begin
          in_flight = 1'b0;
          if (!discard) begin
            exp_valid = 1'b1; exp_vpc = cur_addr; exp_vinstr = rdat; exp_addr = cur_addr + 32'd4;
          end
        end
      end
      if (!exp_valid && !in_flight && !imem_req && (rd || ex)) exp_addr = eff;
      exp_req = !exp_valid;
      @(negedge clk);
    end
    idle_inputs();
    n_checks++; if (delivered < 100) $display("FAIL rnd_progress delivered=%0d exp>=100", delivered); else n_pass++;
    n_checks++; if (errs_seen < 1) $display("FAIL rnd_err_coverage seen=%0d exp>=1", errs_seen); else n_pass++;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_pending();
    test_misaligned();
    test_exc_priority();
    test_wrap();
    test_halt();
    test_reset_mid_fetch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
